uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Byte FIFO that sits directly upstream of the uart transmitter.
//   Producers (text/message generators, debug dumpers) push bytes at any rate.
//   The block drains them to the uart using its tx_rdy/tx_en level handshake,
//   so producers never have to sequence the uart themselves.
// PARAMETERS
//   DW     8   data width in bits
//   AW     4   address width; DEPTH = 2**AW entries (16 by default)
// PORTS
//   clk_50m   in   1     system clock, 50 MHz, all logic on the rising edge
//   rst_n     in   1     asynchronous reset, active low
//   flush     in   1     synchronous clear of the FIFO contents and overflow flag
//   wr_en     in   1     push wr_data this cycle
//   wr_data   in   DW    byte to push
//   full      out  1     count == DEPTH
//   empty     out  1     count == 0
//   count     out  AW+1  number of stored bytes, range 0..DEPTH
//   overflow  out  1     sticky: a push was attempted while full
//   tx_rdy    in   1     uart ready, level; goes low while a byte is in flight
//   tx_en     out  1     byte-valid strobe to the uart
//   tx_data   out  DW    byte to the uart
// BEHAVIOUR
//   - Reset (rst_n low, asynchronous): rptr=wptr=0, count=0, empty=1, full=0,
//     overflow=0, tx_en=0, tx_data=0, state=IDLE. tx_en drops immediately,
//     including mid-handshake. Memory contents are don't-care.
//   - Storage is DEPTH x DW. rptr and wptr are AW bits and wrap modulo DEPTH.
//     count is an up/down counter.
//   - Push: wr_en & ~full -> mem[wptr]<=wr_data, wptr++.
//     wr_en & full -> byte dropped, overflow<=1.
//     full is the registered value: a push is dropped even if a pop happens
//     in the same cycle.
//   - FSM states: IDLE and SEND.
//     IDLE: if tx_rdy & ~empty: tx_data<=mem[rptr], tx_en<=1, rptr++, -> SEND.
//     SEND: hold tx_en=1 and tx_data stable. When tx_rdy==0: tx_en<=0, -> IDLE.
//     IDLE does not launch again until tx_rdy is sampled high, so there is
//     at most one byte per uart ready cycle.
//   - Pop and push in the same cycle leaves count unchanged; both pointers advance.
//   - Latency: a push sampled at edge k into an empty FIFO, with tx_rdy high,
//     gives tx_en=1 after edge k+1.
//   - flush (priority over push): rptr=wptr=0, count=0, overflow=0.
//     A push in the same cycle as flush is ignored.
//     flush does not abort SEND: the byte already handed off completes its
//     handshake normally.
//   - overflow clears only on flush or reset.
//   - full and empty are decoded from count. They are never both high.
// TESTING
//   1 Assert rst_n=0 mid-SEND -> tx_en=0 at once; after release: empty=1,
//     count=0, full=0, overflow=0.
//   2 Push 0x48,0x69,0x0D,0x0A on back-to-back cycles. The uart model drops
//     tx_rdy 2 cycles after tx_en and raises it 10 cycles later.
//     -> 4 tx_en pulses carrying 48,69,0D,0A in order; empty=1 at the end.
//   3 Hold tx_rdy=0 and push 16 bytes -> full=1, count=16.
//     A 17th push of 0xFF -> dropped, overflow=1.
//     Release tx_rdy -> exactly 16 bytes out, no 0xFF.
//   4 Push 40 bytes (0x00..0x27) in bursts of 10 while draining
//     -> all 40 emitted in order across pointer wrap.
//   5 At count=5, push in the same cycle IDLE pops -> count stays 5 and data
//     order is preserved.
//   6 Assert flush while in SEND with count=7 -> the current byte completes,
//     count=0, overflow=0, no further tx_en pulses.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the uart transmitter.
// Drains stored bytes over the tx_rdy/tx_en level handshake.
module uart_tx_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk_50m,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          tx_rdy,
  output logic          tx_en,
  output logic [DW-1:0] tx_data
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW + 1)'(1);
  localparam logic [AW-1:0] PONE = AW'(1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  state_t        state;
  state_t        state_nx;
  logic          tx_en_nx;
  logic [DW-1:0] tx_data_nx;
  logic          push;
  logic          pop;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign push  = wr_en & ~full & ~flush;

  // Storage write port; contents need no reset.
  always_ff @(posedge clk_50m) begin
    if (push) begin
      mem[wptr] <= wr_data;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + PONE;
      end
      if (pop) begin
        rptr <= rptr + PONE;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Handshake state and the registered uart outputs.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx_en   <= 1'b0;
      tx_data <= '0;
    end else begin
      state   <= state_nx;
      tx_en   <= tx_en_nx;
      tx_data <= tx_data_nx;
    end
  end

  // Launch one byte per uart ready phase; a flush cycle never launches.
  always_comb begin
    state_nx   = state;
    tx_en_nx   = tx_en;
    tx_data_nx = tx_data;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_rdy && !empty && !flush) begin
          pop        = 1'b1;
          tx_en_nx   = 1'b1;
          tx_data_nx = mem[rptr];
          state_nx   = SEND;
        end
      end
      SEND: begin
        if (!tx_rdy) begin
          tx_en_nx = 1'b0;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        tx_en_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo.
// Vector table plus multi-cycle handshake sequences.
module tb_uart_tx_fifo;

  logic       clk_50m = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       tx_rdy;
  logic       tx_en;
  logic [7:0] tx_data;

  logic man_rdy;
  logic uart_mode;
  logic model_rdy;
  int   hs;
  int   lo;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] rx_q [$];
  logic       en_q = 1'b0;

  assign tx_rdy = uart_mode ? model_rdy : man_rdy;

  uart_tx_fifo #(.DW(8), .AW(4)) dut (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .overflow(overflow),
    .tx_rdy  (tx_rdy),
    .tx_en   (tx_en),
    .tx_data (tx_data)
  );

  always #5 clk_50m = ~clk_50m;

  always @(negedge clk_50m) begin
    if (tx_en && !en_q) begin
      rx_q.push_back(tx_data);
    end
    en_q = tx_en;
  end

  always @(negedge clk_50m) begin
    if (!uart_mode) begin
      model_rdy = 1'b1;
      hs = 0;
      lo = 0;
    end else if (model_rdy) begin
      if (tx_en) begin
        hs = hs + 1;
        if (hs == 2) begin
          model_rdy = 1'b0;
          hs = 0;
          lo = 0;
        end
      end
    end else begin
      lo = lo + 1;
      if (lo == 10) begin
        model_rdy = 1'b1;
      end
    end
  end

  typedef struct {
    logic       fl;
    logic       we;
    logic [7:0] wd;
    logic       rdy;
    int         cnt;
    logic       emp;
    logic       ful;
    logic       ov;
    logic       en;
    logic [7:0] dat;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  task automatic push_seq(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      wr_data = base + 8'(i);
      tick(1);
    end
    wr_en = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  task automatic wait_rx(input int base, input int n, input int budget,
                         input string name);
    int c;
    c = 0;
    while ((rx_q.size() - base) < n && c < budget) begin
      tick(1);
      c++;
    end
    if ((rx_q.size() - base) < n) begin
      check({name, "_timeout"}, rx_q.size() - base, n);
    end
  endtask

  task automatic check_rx(input int base, input logic [7:0] first,
                          input int n, input string name);
    check({name, "_nbytes"}, rx_q.size() - base, n);
    for (int i = 0; i < n && (base + i) < rx_q.size(); i++) begin
      check($sformatf("%s_byte%0d", name, i),
            int'(rx_q[base+i]), int'(first + 8'(i)));
    end
  endtask

  initial begin
    int base;
    int c;
    logic [7:0] b2 [4];

    tbl[0] = '{0, 1, 8'h11, 0, 1, 0, 0, 0, 0, 8'h00};
    tbl[1] = '{0, 1, 8'h22, 0, 2, 0, 0, 0, 0, 8'h00};
    tbl[2] = '{0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 8'h11};
    tbl[3] = '{0, 1, 8'h33, 1, 2, 0, 0, 0, 1, 8'h11};
    tbl[4] = '{0, 0, 8'h00, 0, 2, 0, 0, 0, 0, 8'h11};
    tbl[5] = '{0, 1, 8'h44, 1, 2, 0, 0, 0, 1, 8'h22};
    tbl[6] = '{0, 0, 8'h00, 0, 2, 0, 0, 0, 0, 8'h22};
    tbl[7] = '{1, 1, 8'h99, 0, 0, 1, 0, 0, 0, 8'h22};
    tbl[8] = '{0, 0, 8'h00, 1, 0, 1, 0, 0, 0, 8'h22};
    tbl[9] = '{0, 1, 8'h77, 0, 1, 0, 0, 0, 0, 8'h22};

    rst_n = 1'b0;
    flush = 1'b0;
    wr_en = 1'b0;
    wr_data = 8'h00;
    man_rdy = 1'b0;
    uart_mode = 1'b0;
    #22;
    check("rst_count", count, 0);
    check("rst_flags", {empty, full, overflow, tx_en}, 4'b1000);
    check("rst_txdata", tx_data, 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    for (int i = 0; i < 10; i++) begin
      flush = tbl[i].fl;
      wr_en = tbl[i].we;
      wr_data = tbl[i].wd;
      man_rdy = tbl[i].rdy;
      tick(1);
      check($sformatf("vec%0d_count", i), count, tbl[i].cnt);
      check($sformatf("vec%0d_flags", i), {empty, full, overflow},
            {tbl[i].emp, tbl[i].ful, tbl[i].ov});
      check($sformatf("vec%0d_tx", i), {tx_en, tx_data},
            {tbl[i].en, tbl[i].dat});
    end
    flush = 1'b0;
    wr_en = 1'b0;
    man_rdy = 1'b0;
    do_flush();

    // reset in the middle of a handshake
    man_rdy = 1'b1;
    push_seq(8'h5A, 1);
    tick(1);
    check("t1_insend", {tx_en, tx_data}, {1'b1, 8'h5A});
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_async_txen", tx_en, 0);
    tick(1);
    rst_n = 1'b1;
    man_rdy = 1'b0;
    tick(1);
    check("t1_post", {empty, full, overflow, tx_en}, 4'b1000);
    check("t1_count", count, 0);

    // four bytes through the uart model
    base = rx_q.size();
    uart_mode = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h48; tick(1);
    wr_data = 8'h69; tick(1);
    wr_data = 8'h0D; tick(1);
    wr_data = 8'h0A; tick(1);
    wr_en = 1'b0;
    wait_rx(base, 4, 300, "t2");
    tick(20);
    b2[0] = 8'h48; b2[1] = 8'h69; b2[2] = 8'h0D; b2[3] = 8'h0A;
    check("t2_nbytes", rx_q.size() - base, 4);
    for (int i = 0; i < 4 && (base + i) < rx_q.size(); i++) begin
      check($sformatf("t2_byte%0d", i), rx_q[base+i], b2[i]);
    end
    check("t2_empty", empty, 1);
    uart_mode = 1'b0;
    tick(1);

    // fill to full, then overflow
    man_rdy = 1'b0;
    base = rx_q.size();
    push_seq(8'hA0, 16);
    check("t3_full", {full, empty}, 2'b10);
    check("t3_count16", count, 16);
    check("t3_ov_pre", overflow, 0);
    push_seq(8'hFF, 1);
    check("t3_ov", overflow, 1);
    check("t3_count_hold", count, 16);
    uart_mode = 1'b1;
    wait_rx(base, 16, 600, "t3");
    tick(40);
    check_rx(base, 8'hA0, 16, "t3");
    check("t3_ov_sticky", overflow, 1);
    uart_mode = 1'b0;
    do_flush();
    check("t3_ov_flushed", overflow, 0);

    // 40 bytes across pointer wrap
    base = rx_q.size();
    uart_mode = 1'b1;
    for (int b = 0; b < 4; b++) begin
      push_seq(8'(b * 10), 10);
      c = 0;
      while (count > 4 && c < 400) begin
        tick(1);
        c++;
      end
    end
    wait_rx(base, 40, 2000, "t4");
    tick(30);
    check_rx(base, 8'h00, 40, "t4");
    check("t4_ov", overflow, 0);
    uart_mode = 1'b0;
    tick(1);

    // simultaneous push and pop at count 5
    man_rdy = 1'b0;
    do_flush();
    base = rx_q.size();
    push_seq(8'h50, 5);
    check("t5_count5", count, 5);
    man_rdy = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h55;
    tick(1);
    wr_en = 1'b0;
    man_rdy = 1'b0;
    check("t5_count_same", count, 5);
    check("t5_tx", {tx_en, tx_data}, {1'b1, 8'h50});
    tick(1);
    uart_mode = 1'b1;
    wait_rx(base, 6, 400, "t5");
    tick(30);
    check_rx(base, 8'h50, 6, "t5");
    uart_mode = 1'b0;
    tick(1);

    // flush during SEND
    man_rdy = 1'b0;
    do_flush();
    base = rx_q.size();
    push_seq(8'h60, 8);
    man_rdy = 1'b1;
    tick(1);
    check("t6_count7", count, 7);
    check("t6_send", {tx_en, tx_data}, {1'b1, 8'h60});
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("t6_flushed", {count, overflow}, 6'b0);
    check("t6_hold", {tx_en, tx_data}, {1'b1, 8'h60});
    man_rdy = 1'b0;
    tick(1);
    check("t6_done", tx_en, 0);
    man_rdy = 1'b1;
    tick(20);
    check("t6_nbytes", rx_q.size() - base, 1);
    check("t6_idle", {tx_en, empty}, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
